// File: rtl/ps2_scan_decoder.sv
// PS/2 keyboard event decoder: folds E0/F0/E1 scan-code sequences into single
// key events, tracks held modifiers, buffers events in a small FIFO with a
// valid/ready handshake and counts receiver errors.
module ps2_scan_decoder #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       computerClk,
  input  logic       rst,
  input  logic       byte_valid,
  input  logic [7:0] byte_data,
  input  logic       byte_err,
  output logic       evt_valid,
  input  logic       evt_ready,
  output logic [7:0] evt_code,
  output logic       evt_ext,
  output logic       evt_release,
  output logic [2:0] modifiers,
  output logic       overflow,
  output logic [7:0] err_count
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_EXT,
    S_REL,
    S_EXT_REL,
    S_PAUSE
  } state_t;

  state_t      state_q;
  logic [2:0]  skip_q;
  logic        emit_d;
  logic [7:0]  code_d;
  logic        ext_d;
  logic        rel_d;
  logic [5:0]  held_q;
  logic [7:0]  err_q;
  logic [9:0]  mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_q;
  logic [AW-1:0] rd_q;
  logic [CW-1:0] cnt_q;
  logic        ovf_q;
  logic        full;
  logic        pop;
  logic        push_ok;
  logic [9:0]  head;

  // Keyboard command responses that carry no key information
  function automatic logic is_response(input logic [7:0] b);
    return b inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF};
  endfunction

  // Saturating increment for the error counter
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Decide whether the current byte completes a key event and what it is
  always_comb begin
    emit_d = 1'b0;
    code_d = byte_data;
    ext_d  = 1'b0;
    rel_d  = 1'b0;
    if (byte_valid && !byte_err) begin
      case (state_q)
        S_IDLE: begin
          if (!(byte_data inside {8'hE0, 8'hF0, 8'hE1}) && !is_response(byte_data))
            emit_d = 1'b1;
        end
        S_EXT: begin
          if (byte_data != 8'hF0 && byte_data != 8'hE0) begin
            emit_d = 1'b1;
            ext_d  = 1'b1;
          end
        end
        S_REL: begin
          if (byte_data != 8'hF0 && byte_data != 8'hE0) begin
            emit_d = 1'b1;
            rel_d  = 1'b1;
          end
        end
        S_EXT_REL: begin
          if (byte_data != 8'hF0 && byte_data != 8'hE0) begin
            emit_d = 1'b1;
            ext_d  = 1'b1;
            rel_d  = 1'b1;
          end
        end
        S_PAUSE: begin
          if (skip_q == 3'd1) begin
            emit_d = 1'b1;
            code_d = 8'h77;
            ext_d  = 1'b1;
          end
        end
        default: emit_d = 1'b0;
      endcase
    end
  end

  // Prefix-tracking state machine; an errored byte abandons any partial sequence
  always_ff @(posedge computerClk) begin
    if (rst) begin
      state_q <= S_IDLE;
      skip_q  <= 3'd0;
    end else if (byte_valid) begin
      if (byte_err) begin
        state_q <= S_IDLE;
        skip_q  <= 3'd0;
      end else begin
        case (state_q)
          S_IDLE: begin
            case (byte_data)
              8'hE0:   state_q <= S_EXT;
              8'hF0:   state_q <= S_REL;
              8'hE1: begin
                state_q <= S_PAUSE;
                skip_q  <= 3'd7;
              end
              default: state_q <= S_IDLE;
            endcase
          end
          S_EXT: begin
            case (byte_data)
              8'hF0:   state_q <= S_EXT_REL;
              8'hE0:   state_q <= S_EXT;
              default: state_q <= S_IDLE;
            endcase
          end
          S_REL: begin
            case (byte_data)
              8'hF0:   state_q <= S_REL;
              8'hE0:   state_q <= S_EXT_REL;
              default: state_q <= S_IDLE;
            endcase
          end
          S_EXT_REL: begin
            if (byte_data != 8'hE0 && byte_data != 8'hF0) state_q <= S_IDLE;
          end
          S_PAUSE: begin
            skip_q <= skip_q - 3'd1;
            if (skip_q <= 3'd1) state_q <= S_IDLE;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  // Per-key held flags; updated on every emitted event, even one the FIFO drops
  always_ff @(posedge computerClk) begin
    if (rst) begin
      held_q <= 6'd0;
    end else if (emit_d) begin
      case ({ext_d, code_d})
        {1'b0, 8'h12}: held_q[0] <= !rel_d;
        {1'b0, 8'h59}: held_q[1] <= !rel_d;
        {1'b0, 8'h14}: held_q[2] <= !rel_d;
        {1'b1, 8'h14}: held_q[3] <= !rel_d;
        {1'b0, 8'h11}: held_q[4] <= !rel_d;
        {1'b1, 8'h11}: held_q[5] <= !rel_d;
        default: ;
      endcase
    end
  end

  assign modifiers = {held_q[5] | held_q[4], held_q[3] | held_q[2], held_q[1] | held_q[0]};

  // Receiver error counter, saturating
  always_ff @(posedge computerClk) begin
    if (rst) begin
      err_q <= 8'd0;
    end else if (byte_valid && byte_err) begin
      err_q <= sat_inc8(err_q);
    end
  end

  assign err_count = err_q;

  assign full    = (cnt_q == CW'(FIFO_DEPTH));
  assign pop     = evt_valid & evt_ready;
  assign push_ok = emit_d & (!full | pop);

  // Event storage; at full with a simultaneous pop the write lands in the slot being vacated
  always_ff @(posedge computerClk) begin
    if (push_ok) mem_q[wr_q] <= {ext_d, rel_d, code_d};
  end

  // FIFO pointers, occupancy and sticky overflow flag
  always_ff @(posedge computerClk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      if (push_ok) wr_q <= wr_q + AW'(1);
      if (pop)     rd_q <= rd_q + AW'(1);
      case ({push_ok, pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
      if (emit_d && full && !pop) ovf_q <= 1'b1;
    end
  end

  assign overflow    = ovf_q;
  assign evt_valid   = (cnt_q != '0);
  assign head        = mem_q[rd_q];
  assign evt_code    = evt_valid ? head[7:0] : 8'h00;
  assign evt_release = evt_valid ? head[8] : 1'b0;
  assign evt_ext     = evt_valid ? head[9] : 1'b0;

endmodule
